irq_ctrl: RTL
=============

Name: irq_ctrl

Overview:
- Interrupt controller; the receiving end of the timer/peripheral request handshake.
- Latches sticky request lines such as tmr_req, masks and prioritises them, and raises one irq with a vector to the MIPS core.
- On CPU acknowledge, pulses the matching src_clr line back to the source, which clears the source's sticky flag.
- Sits between the peripheral block and the core's exception logic; a memory-mapped register file sits on the data bus.

Parameters:
- N_SRC, 4, number of request sources (1..16).
- ID_W, 2, vector width; must equal clog2(N_SRC), minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  N_SRC  sticky level requests from sources (tmr_req etc.).
- src_clr  out  N_SRC  one-cycle clear pulses to sources, registered.
- wr_en  in  1  register write strobe, sampled on clk.
- wr_addr  in  2  write register select.
- wr_data  in  32  write data.
- rd_addr  in  2  read register select.
- rd_data  out  32  read data, combinational from registers.
- irq  out  1  interrupt to core, registered.
- irq_vec  out  ID_W  id of the asserted source; valid while irq=1, else 0.

Behaviour:
- Registers (word index):
  - 0 MASK: rw, bit i=1 enables source i. Reset 0.
  - 1 PEND: read-only pending bits; writing 1 clears a bit (W1C). Reset 0.
  - 2 VEC: ro; bit31 = irq, bits[ID_W-1:0] = irq_vec. Writes ignored.
  - 3 CTRL: rw; bit0 = global enable GEN. Reset 0.
  - Unused read bits return 0.
- Reset (rst=0, async): all registers, req_q, state, irq, irq_vec and src_clr go to 0; state = IDLE.
- Edge capture:
  - req_q <= req every cycle.
  - pend[i] sets on an edge where req[i]=1 and req_q[i]=0.
  - Masked sources still set PEND.
- W1C: a PEND write with bit i=1 clears pend[i] and sets src_clr[i]=1 for the following cycle only.
- Same-edge set and W1C on one bit: set wins; src_clr still pulses.
- Arbitration: eligible = pend & MASK, gated by GEN. The lowest index has the highest priority.
- FSM:
  - IDLE: if eligible != 0, latch winner id into irq_vec, set irq=1, go ASSERT.
  - ASSERT: irq stays 1 and irq_vec is held, even if higher-priority requests arrive or MASK changes.
    - A W1C hitting bit irq_vec: irq=0 next cycle, go HOLDOFF.
    - GEN written 0: irq=0, irq_vec=0, go IDLE; PEND is retained.
    - A W1C of other bits clears those bits only; no state change.
  - HOLDOFF: one cycle with irq=0 so the source flag drops, then IDLE.
- Latency:
  - req rises before edge k → pend set at k, irq=1 at k+1.
  - Ack write at edge a → irq=0 and src_clr pulse at a+1; earliest re-assert at a+3.
- A source whose req stays high after src_clr does not re-pend; only a new rising edge re-pends it.
- Widths: wr_data bits above N_SRC are ignored for MASK and PEND.

Decomposition:
- Shared package/include.h:
  - Register indices IRQ_MASK=0, IRQ_PEND=1, IRQ_VEC=2, IRQ_CTRL=3.
  - FSM state encodings IDLE, ASSERT, HOLDOFF.
  - GEN bit position.
- One sub-module, irq_prio_enc: combinational lowest-index priority encoder, N_SRC → {any, id}.

Test Plan:
- Reset: rst low mid-ASSERT → irq=0, irq_vec=0, PEND=0, MASK=0, src_clr=0 asynchronously; rd_data at VEC = 0.
- Basic flow: MASK=4'b0100, GEN=1, raise req[2] → PEND=4'b0100, irq=1 one cycle later with irq_vec=2. Write PEND=4'b0100 → src_clr=4'b0100 for exactly one cycle, irq drops, FSM passes through HOLDOFF.
- Priority and hold:
  - MASK=4'hF; req[3] and req[1] rise together → irq_vec=1.
  - In ASSERT, req[0] rises → irq_vec stays 1.
  - After ack of 1 and HOLDOFF → irq_vec=0, then 3 after the next ack.
- Masking and GEN:
  - MASK=0, req[0] rises → PEND bit0=1, irq=0.
  - Set MASK bit0 → irq=1 two edges later.
  - Write GEN=0 during ASSERT → irq=0, PEND still 1.
- Set/clear collision: W1C of bit1 on the same edge req[1] rises → pend[1]=1 afterward, src_clr[1] pulses once.
- Stuck source: req[2] held high through ack → no re-pend, irq stays 0. Drop req[2] for one cycle and raise again → pend[2]=1, irq re-asserts.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register map, FSM states
// and control-register bit positions.
package irq_ctrl_pkg;

    localparam logic [1:0] IRQ_MASK = 2'd0;
    localparam logic [1:0] IRQ_PEND = 2'd1;
    localparam logic [1:0] IRQ_VEC  = 2'd2;
    localparam logic [1:0] IRQ_CTRL = 2'd3;

    localparam int GEN_BIT = 0;
    localparam int VEC_IRQ_BIT = 31;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        HOLDOFF = 2'd2
    } irq_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: reports whether any bit is set and the
// index of the lowest set bit (lowest index wins).
module irq_prio_enc #(
    parameter int N_SRC = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_SRC-1:0] req_vec,
    output logic             any,
    output logic [ID_W-1:0]  id
);

    // Scan from the top down so the last hit, the lowest index, is kept.
    always_comb begin
        any = 1'b0;
        id  = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                any = 1'b1;
                id  = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: captures rising edges of sticky source requests,
// masks and prioritises them, and raises one irq with a vector to the core.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int ID_W  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] req,
    output logic [N_SRC-1:0] src_clr,
    input  logic             wr_en,
    input  logic [1:0]       wr_addr,
    input  logic [31:0]      wr_data,
    input  logic [1:0]       rd_addr,
    output logic [31:0]      rd_data,
    output logic             irq,
    output logic [ID_W-1:0]  irq_vec
);

    logic [N_SRC-1:0] req_q;
    logic [N_SRC-1:0] pend;
    logic [N_SRC-1:0] mask;
    logic             gen;

    logic [N_SRC-1:0] rising;
    logic [N_SRC-1:0] w1c;
    logic [N_SRC-1:0] eligible;
    logic             gen_off_wr;
    logic             enc_any;
    logic [ID_W-1:0]  enc_id;

    irq_state_t       state;
    irq_state_t       state_next;
    logic             irq_next;
    logic [ID_W-1:0]  vec_next;

    logic             unused_wr_bits;

    assign rising         = req & ~req_q;
    assign w1c            = (wr_en && wr_addr == IRQ_PEND) ? wr_data[N_SRC-1:0] : '0;
    assign gen_off_wr     = wr_en && (wr_addr == IRQ_CTRL) && !wr_data[GEN_BIT];
    assign eligible       = pend & mask & {N_SRC{gen}};
    assign unused_wr_bits = ^wr_data[31:N_SRC];

    irq_prio_enc #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) u_prio_enc (
        .req_vec (eligible),
        .any     (enc_any),
        .id      (enc_id)
    );

    // A new edge on the same cycle as a W1C keeps the bit set, so no edge is lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q   <= '0;
            pend    <= '0;
            mask    <= '0;
            gen     <= 1'b0;
            src_clr <= '0;
        end else begin
            req_q   <= req;
            pend    <= (pend & ~w1c) | rising;
            src_clr <= w1c;
            if (wr_en && wr_addr == IRQ_MASK) begin
                mask <= wr_data[N_SRC-1:0];
            end
            if (wr_en && wr_addr == IRQ_CTRL) begin
                gen <= wr_data[GEN_BIT];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            irq     <= 1'b0;
            irq_vec <= '0;
        end else begin
            state   <= state_next;
            irq     <= irq_next;
            irq_vec <= vec_next;
        end
    end

    // The vector is frozen for the whole ASSERT phase; only an ack of that
    // source or a global disable releases it.
    always_comb begin
        state_next = state;
        irq_next   = irq;
        vec_next   = irq_vec;
        case (state)
            IDLE: begin
                if (enc_any) begin
                    state_next = ASSERT;
                    irq_next   = 1'b1;
                    vec_next   = enc_id;
                end
            end
            ASSERT: begin
                if (gen_off_wr) begin
                    state_next = IDLE;
                    irq_next   = 1'b0;
                    vec_next   = '0;
                end else if (w1c[irq_vec]) begin
                    state_next = HOLDOFF;
                    irq_next   = 1'b0;
                    vec_next   = '0;
                end
            end
            HOLDOFF: begin
                state_next = IDLE;
                irq_next   = 1'b0;
                vec_next   = '0;
            end
            default: begin
                state_next = IDLE;
                irq_next   = 1'b0;
                vec_next   = '0;
            end
        endcase
    end

    always_comb begin
        rd_data = '0;
        case (rd_addr)
            IRQ_MASK: rd_data[N_SRC-1:0] = mask;
            IRQ_PEND: rd_data[N_SRC-1:0] = pend;
            IRQ_VEC: begin
                rd_data[VEC_IRQ_BIT] = irq;
                rd_data[ID_W-1:0]    = irq_vec;
            end
            IRQ_CTRL: rd_data[GEN_BIT] = gen;
            default: rd_data = '0;
        endcase
    end

endmodule
